// File: rtl/tpic_readback_if.sv
// tpic_readback_if -- signal bundle between a host and the TPIC chain readback block.
//   start     : host -> block, one-cycle request to begin a readback pass
//   expected  : host -> block, relay image last written to the chain
//   miso      : chain -> block, serial output of the last chain stage
//   sclk      : block -> chain, shift clock
//   mosi      : block -> chain, recirculated expected image
//   busy      : block -> host, pass in progress
//   done      : block -> host, one-cycle pass-complete pulse
//   data      : block -> host, captured chain contents
//   mismatch  : block -> host, captured contents differ from the snapshot
//   err_count : block -> host, number of differing bits
//   first_err : block -> host, index of the first differing bit captured
// Modport slave is the readback block; master is the host/chain side.
interface tpic_readback_if #(
  parameter int WIDTH = 300
);
  localparam int KW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int ECW = $clog2(WIDTH + 1);

  logic             start;
  logic [WIDTH-1:0] expected;
  logic             miso;
  logic             sclk;
  logic             mosi;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] data;
  logic             mismatch;
  logic [ECW-1:0]   err_count;
  logic [KW-1:0]    first_err;

  modport slave (
    input  start, expected, miso,
    output sclk, mosi, busy, done, data, mismatch, err_count, first_err
  );

  modport master (
    output start, expected, miso,
    input  sclk, mosi, busy, done, data, mismatch, err_count, first_err
  );
endinterface

// File: rtl/tpic_readback.sv
// tpic_readback -- reads back a TPIC shift-register relay chain without
// disturbing it. The expected image is shifted back in on mosi while the
// chain contents come out on miso, so after a full pass the chain shift
// registers hold the snapshot again; rck/enable are never touched.
// Ports:
//   clk     : system clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : tpic_readback_if.slave (start/expected/miso in;
//             sclk/mosi/busy/done/data/mismatch/err_count/first_err out)
// Timing: each bit takes CLK_DIV cycles with sclk low then CLK_DIV cycles
// with sclk high; miso is sampled on the last low cycle, just before the
// chain shifts on the sclk rising edge.
module tpic_readback #(
  parameter int WIDTH   = 300,
  parameter int CLK_DIV = 2
) (
  input logic           clk,
  input logic           reset_n,
  tpic_readback_if.slave bus
);
  localparam int KW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int ECW = $clog2(WIDTH + 1);
  localparam int CW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] snap_reg;
  logic [WIDTH-1:0] data_reg;
  logic [KW-1:0]    k_reg;
  logic [CW-1:0]    cnt_reg;
  logic             sclk_reg;
  logic             mosi_reg;
  logic             busy_reg;
  logic             done_reg;
  logic             mismatch_reg;
  logic [ECW-1:0]   err_count_reg;
  logic [KW-1:0]    first_err_reg;

  // Bit position currently on the wire; highest index goes first.
  logic [KW-1:0] idx;
  assign idx = KW'(WIDTH - 1) - k_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      snap_reg      <= '0;
      data_reg      <= '0;
      k_reg         <= '0;
      cnt_reg       <= '0;
      sclk_reg      <= 1'b0;
      mosi_reg      <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      mismatch_reg  <= 1'b0;
      err_count_reg <= '0;
      first_err_reg <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          sclk_reg <= 1'b0;
          busy_reg <= 1'b0;
          if (bus.start) begin
            snap_reg      <= bus.expected;
            data_reg      <= '0;
            err_count_reg <= '0;
            mismatch_reg  <= 1'b0;
            first_err_reg <= '0;
            k_reg         <= '0;
            cnt_reg       <= '0;
            mosi_reg      <= bus.expected[WIDTH-1];
            busy_reg      <= 1'b1;
            state_reg     <= LOW;
          end
        end

        LOW: begin
          if (cnt_reg == CW'(CLK_DIV - 1)) begin
            cnt_reg       <= '0;
            data_reg[idx] <= bus.miso;
            if (bus.miso != snap_reg[idx]) begin
              // Saturation is unnecessary: at most WIDTH bits can differ.
              err_count_reg <= err_count_reg + ECW'(1);
              if (!mismatch_reg) begin
                mismatch_reg  <= 1'b1;
                first_err_reg <= idx;
              end
            end
            sclk_reg  <= 1'b1;
            state_reg <= HIGH;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end

        HIGH: begin
          if (cnt_reg == CW'(CLK_DIV - 1)) begin
            cnt_reg  <= '0;
            sclk_reg <= 1'b0;
            if (k_reg == KW'(WIDTH - 1)) begin
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
              state_reg <= DONE;
            end else begin
              k_reg     <= k_reg + KW'(1);
              // Next bit down; mosi changes only while sclk is low.
              mosi_reg  <= snap_reg[idx - KW'(1)];
              state_reg <= LOW;
            end
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end

        DONE: begin
          // start is deliberately not looked at here.
          state_reg <= IDLE;
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.sclk      = sclk_reg;
  assign bus.mosi      = mosi_reg;
  assign bus.busy      = busy_reg;
  assign bus.done      = done_reg;
  assign bus.data      = data_reg;
  assign bus.mismatch  = mismatch_reg;
  assign bus.err_count = err_count_reg;
  assign bus.first_err = first_err_reg;
endmodule

// File: tb/tb_tpic_readback.sv
// tb_tpic_readback -- bench for tpic_readback (WIDTH=8, CLK_DIV=2) with an
// 8-bit shift-register model of the TPIC chain on sclk/mosi/miso.
module tb_tpic_readback;
  logic clk = 1'b0;
  logic reset_n;

  always #10 clk = ~clk;

  tpic_readback_if #(.WIDTH(8)) bus ();

  tpic_readback #(.WIDTH(8), .CLK_DIV(2)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Chain model: shifts on sclk rise, last stage drives miso.
  logic [7:0] chain;
  logic       load;
  logic [7:0] load_val;
  always @(posedge bus.sclk or posedge load) begin
    if (load) chain <= load_val;
    else      chain <= {chain[6:0], bus.mosi};
  end
  assign bus.miso = chain[7];

  typedef struct {
    logic [7:0] data;
    logic       mm;
    logic [3:0] ec;
    logic [2:0] fe;
    logic [7:0] chain_after;
    int         start_cyc;
    int         sclk_base;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   sclk_total = 0;
  int   done_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge bus.sclk);
    sclk_total++;
  end

  // Monitor: every done pulse pops one expectation.
  initial forever begin
    @(negedge clk);
    if (bus.done === 1'b1) begin
      done_cnt++;
      chk("sb_has_entry", sb.size(), (sb.size() > 0) ? sb.size() : 1);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        $display("pass %0d: data=%02h mismatch=%0d err_count=%0d first_err=%0d chain=%02h latency=%0d",
                 done_cnt, bus.data, bus.mismatch, bus.err_count, bus.first_err,
                 chain, cyc - e.start_cyc);
        chk("data",      32'(bus.data),      32'(e.data));
        chk("mismatch",  32'(bus.mismatch),  32'(e.mm));
        chk("err_count", 32'(bus.err_count), 32'(e.ec));
        chk("first_err", 32'(bus.first_err), 32'(e.fe));
        chk("chain_restored", 32'(chain),    32'(e.chain_after));
        chk("latency",   cyc - e.start_cyc,  33);
        chk("sclk_pulses", sclk_total - e.sclk_base, 8);
        chk("busy_at_done", 32'(bus.busy),   0);
      end
    end
  end

  task automatic start_pass(input logic [7:0] ch, input logic [7:0] ex, input bit push,
                            input logic [7:0] d, input logic mm, input logic [3:0] ec,
                            input logic [2:0] fe, output int s);
    exp_t e;
    @(negedge clk);
    load_val = ch;
    load = 1'b1;
    #1;
    load = 1'b0;
    bus.expected = ex;
    bus.start = 1'b1;
    s = cyc;
    if (push) begin
      e.data = d; e.mm = mm; e.ec = ec; e.fe = fe;
      e.chain_after = ex; e.start_cyc = s; e.sclk_base = sclk_total;
      sb.push_back(e);
    end
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int target);
    bit seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (done_cnt >= target) seen = 1'b1;
    end
    chk("done_seen", done_cnt, target);
  endtask

  initial begin
    int  s;
    bit  hit;
    reset_n = 1'b0;
    bus.start = 1'b0;
    bus.expected = '0;
    load = 1'b0;
    load_val = '0;
    repeat (3) @(negedge clk);
    chk("rst_sclk",      32'(bus.sclk),      0);
    chk("rst_mosi",      32'(bus.mosi),      0);
    chk("rst_busy",      32'(bus.busy),      0);
    chk("rst_done",      32'(bus.done),      0);
    chk("rst_data",      32'(bus.data),      0);
    chk("rst_mismatch",  32'(bus.mismatch),  0);
    chk("rst_err_count", 32'(bus.err_count), 0);
    chk("rst_first_err", 32'(bus.first_err), 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Clean chain, single low-bit error, all bits wrong, scattered errors.
    start_pass(8'hA5, 8'hA5, 1'b1, 8'hA5, 1'b0, 4'd0, 3'd0, s); wait_done(1);
    start_pass(8'hA4, 8'hA5, 1'b1, 8'hA4, 1'b1, 4'd1, 3'd0, s); wait_done(2);
    start_pass(8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, 4'd8, 3'd7, s); wait_done(3);
    start_pass(8'h12, 8'h34, 1'b1, 8'h12, 1'b1, 4'd3, 3'd5, s); wait_done(4);

    // start re-pulsed in cycle 10 and in the DONE cycle must be ignored.
    start_pass(8'h3C, 8'h1C, 1'b1, 8'h3C, 1'b1, 4'd1, 3'd5, s);
    repeat (9) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) hit = 1'b1;
    end
    chk("done_cycle_reached", 32'(hit), 1);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (6) @(negedge clk);
    chk("no_restart_busy", 32'(bus.busy), 0);
    chk("single_done", done_cnt, 5);

    // expected changes mid-pass; snapshot must be used.
    start_pass(8'h5A, 8'h5A, 1'b1, 8'h5A, 1'b0, 4'd0, 3'd0, s);
    repeat (4) @(negedge clk);
    bus.expected = 8'h00;
    wait_done(6);

    // Reset during bit 3 (sclk high phase, cycle 15).
    start_pass(8'hF0, 8'h0F, 1'b0, 8'h00, 1'b0, 4'd0, 3'd0, s);
    repeat (14) @(negedge clk);
    chk("pre_reset_sclk", 32'(bus.sclk), 1);
    chk("pre_reset_data", 32'(bus.data), 32'h F0);
    reset_n = 1'b0;
    #1;
    chk("abort_sclk",      32'(bus.sclk),      0);
    chk("abort_busy",      32'(bus.busy),      0);
    chk("abort_data",      32'(bus.data),      0);
    chk("abort_mismatch",  32'(bus.mismatch),  0);
    chk("abort_err_count", 32'(bus.err_count), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("abort_no_done", done_cnt, 6);
    chk("abort_idle_busy", 32'(bus.busy), 0);

    start_pass(8'h81, 8'h80, 1'b1, 8'h81, 1'b1, 4'd1, 3'd0, s); wait_done(7);

    repeat (4) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/tpic_readback.md
TPIC_READBACK -- requirements
Module: tpic_readback

Interface
REQ-001 Parameter WIDTH, default 300: relay chain length in bits, equal to the length used by the chain writer.
REQ-002 Parameter CLK_DIV, default 2: sclk half-period, in clk cycles (>=1).
REQ-003 clk  in  1  system clock (50 MHz); the block has one clock; all logic SHALL be clocked on its rising edge.
REQ-004 reset_n  in  1  reset, asynchronous and active-low.
REQ-005 start  in  1  one-cycle request to begin a readback pass.
REQ-006 expected  in  WIDTH  flat relay image last written to the chain.
REQ-007 miso  in  1  TPIC chain serial output (last stage SO).
REQ-008 sclk  out  1  TPIC shift clock.
REQ-009 mosi  out  1  TPIC chain serial input, recirculating the expected image.
REQ-010 busy  out  1  high while a pass is in progress.
REQ-011 done  out  1  one-cycle pulse when a pass completes.
REQ-012 data  out  WIDTH  captured chain contents.
REQ-013 mismatch  out  1  high if data differs from the snapshot of expected.
REQ-014 err_count  out  $clog2(WIDTH+1)  number of differing bits.
REQ-015 first_err  out  $clog2(WIDTH)  bit index of the first differing bit captured; highest index is captured first.

Function
REQ-016 The FSM SHALL have states IDLE, LOW, HIGH and DONE.
REQ-017 IDLE: sclk=0 and busy=0; when start=1, the block SHALL snapshot expected into an internal register, clear data, err_count, mismatch and first_err, set bit index k=0, and enter LOW.
REQ-018 LOW: sclk=0 and mosi=snap[WIDTH-1-k], held for CLK_DIV cycles.
REQ-019 On the last LOW cycle, the block SHALL sample miso into data[WIDTH-1-k] and compare it with snap[WIDTH-1-k].
REQ-020 On a differing bit, err_count SHALL increment; on the first difference of the pass, mismatch SHALL be set and first_err SHALL load WIDTH-1-k.
REQ-021 HIGH: sclk=1 and mosi held, for CLK_DIV cycles; the block SHALL then increment k and go to LOW if k<WIDTH-1, or to DONE if k=WIDTH-1.
REQ-022 DONE: sclk=0, busy=0, done=1 for exactly one cycle, then IDLE; data, mismatch, err_count and first_err SHALL hold until the next accepted start.
REQ-023 busy SHALL be 1 in LOW and HIGH only.
REQ-024 Latency: with start accepted at edge 0, done SHALL be high in cycle 2*CLK_DIV*WIDTH+1.
REQ-025 start SHALL be ignored in LOW, HIGH and DONE; start in the DONE cycle SHALL be dropped.
REQ-026 Changes on expected during a pass SHALL not affect that pass; only the snapshot is used.
REQ-027 The block SHALL never drive an rck or enable; the chain latches are untouched, and after a full pass the chain shift registers SHALL again hold the snapshot.
REQ-028 err_count SHALL not wrap, since its maximum value is WIDTH.

Reset
REQ-029 While reset_n=0, any state SHALL go to IDLE immediately: sclk=0, mosi=0, busy=0, done=0, data=0, mismatch=0, err_count=0, first_err=0, k=0.
REQ-030 Reset in mid-pass SHALL abandon the pass with no done pulse; sclk SHALL fall asynchronously.

Verification (WIDTH=8, CLK_DIV=2; miso driven by an 8-bit shift-register model of the chain)
REQ-031 Chain preloaded 0xA5, expected=0xA5, start -> 8 sclk pulses, data=0xA5, mismatch=0, err_count=0, done in cycle 33, chain holds 0xA5.
REQ-032 Chain 0xA4, expected=0xA5 -> data=0xA4, mismatch=1, err_count=1, first_err=0.
REQ-033 Chain 0x00, expected=0xFF -> err_count=8, first_err=7.
REQ-034 start pulsed again in cycle 10 and in the DONE cycle -> no restart, exactly one done pulse.
REQ-035 reset_n low during bit 3 -> sclk=0, busy=0, data=0 at once, no done pulse; a new start then completes normally.
REQ-036 expected changed in cycle 5 of a pass -> results compare against the value present at start.
